macc_seq: RTL and testbench
===========================

Name: macc_seq

Overview:
- Sequencer that time-multiplexes one combinational signed multiply-accumulate unit to compute a neuron dot product: acc = bias + sum(x[i]*w[i]) for i = 0..len-1.
- Sits between the operand fetch logic (x/w streams) and the activation/writeback stage.
- Drives the external MACC datapath ports and holds the running accumulator register.
- Issues one result per started job, with valid/ready handshakes.

Parameters:
- DATA_W, 16, signed operand/accumulator width; must match the MACC datapath width.
- CNT_W, 8, width of the job length field; maximum length 2^CNT_W-1.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  job request; accepted only when busy=0
- cfg_len  in  CNT_W  number of operand pairs; sampled when start is accepted
- cfg_bias  in  DATA_W  signed initial accumulator value; sampled when start is accepted
- busy  out  1  job in progress, or result not yet consumed
- op_valid  in  1  operand pair valid
- op_x  in  DATA_W  signed operand x
- op_w  in  DATA_W  signed operand w
- op_ready  out  1  operand pair accepted when op_valid & op_ready
- m_in0  out  DATA_W  to MACC in0, equals op_x
- m_in1  out  DATA_W  to MACC in1, equals op_w
- m_acc  out  DATA_W  to MACC in_acc, equals acc_q
- m_out  in  DATA_W  from MACC, in0*in1+in_acc truncated to DATA_W
- res_valid  out  1  result available
- res_data  out  DATA_W  signed result
- res_ready  in  1  consumer accepts result

Behaviour:
- FSM states: IDLE, ACC, DONE. Reset state is IDLE.
- Reset values: acc_q=0, cnt_q=0, busy=0, op_ready=0, res_valid=0, res_data=0.
- Reset is asynchronous. Asserting rst_n=0 mid-job aborts the job immediately; no result is produced.
- IDLE:
  - busy=0, op_ready=0.
  - On start=1: acc_q<=cfg_bias and cnt_q<=cfg_len.
  - If cfg_len=0, go to DONE. Otherwise go to ACC.
- ACC:
  - busy=1, op_ready=1.
  - On each handshake (op_valid & op_ready): acc_q<=m_out and cnt_q<=cnt_q-1.
  - The handshake on which cnt_q=1 moves the FSM to DONE.
  - No handshake means acc_q and cnt_q hold. op_valid stalls of any length are legal.
- DONE:
  - busy=1, op_ready=0, res_valid=1, res_data=f(acc_q).
  - On res_ready=1, go to IDLE. res_valid drops the next cycle.
  - res_data holds stable while res_valid=1 and res_ready=0.
- start is ignored while busy=1; no queuing.
- A start accepted in IDLE in the same cycle that DONE exits is impossible, because DONE exits to IDLE first. Minimum job turnaround is therefore 1 idle cycle.
- m_in0/m_in1/m_acc are combinational pass-throughs, valid in every state. The MACC output is only registered on a handshake.
- Arithmetic: two's-complement wrap on DATA_W bits, as the MACC truncates. The sequencer performs no extension or saturation.
- Latency: len + 1 cycles from start to res_valid with no stalls, and 1 cycle for len=0.
- Throughput: one operand pair per cycle.

Optional Feature:
- MACC_SEQ_RELU_EN
  - Defined: res_data = (acc_q < 0) ? 0 : acc_q, a ReLU activation applied combinationally on output.
  - Undefined: res_data = acc_q.
- The accumulator itself is unaffected in both cases.

Decomposition:
- Shared package neural_pkg holds:
  - DATA_W default constant
  - state enum typedef {IDLE, ACC, DONE}
  - signed data typedef data_t
- No sub-module: the MACC datapath stays a separate existing unit, instantiated beside macc_seq at the next level up. A top-level wrapper neuron_core ties m_* to the MACC instance.

Test Plan:
- Job 1, no stalls:
  - Stimulus: bias=0, len=1, pair (10,15).
  - Required: res_valid 2 cycles after start, res_data=150.
- Job 2, with stalls:
  - Stimulus: bias=100, len=3, pairs (70,8), (-7,5), (2,-3), with op_valid deasserted 2 cycles between pairs.
  - Required: res_data=100+560-35-6=619; op_ready low outside ACC.
- Job 3, zero length:
  - Stimulus: len=0, bias=-42.
  - Required: res_valid the next cycle, res_data=-42 (0 with MACC_SEQ_RELU_EN).
- Job 4, backpressure:
  - Stimulus: res_ready held low 5 cycles; start pulsed meanwhile.
  - Required: res_data stable, start ignored, busy=1 throughout.
- Job 5, wrap:
  - Stimulus: bias=32767, pair (1,1).
  - Required: res_data=-32768 without RELU, 0 with MACC_SEQ_RELU_EN.
- Job 6, reset mid-operation:
  - Stimulus: rst_n low after 2 of 4 pairs.
  - Required: all outputs at reset values immediately; a new job with bias=0, len=1, pair (3,4) gives 12.

Source files
------------

// File: rtl/neural_pkg.sv
// Shared types and constants for the neuron datapath: default data width,
// sequencer state encoding and the signed data word type.
package neural_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic signed [DATA_W_DEF-1:0] data_t;

endpackage

// File: rtl/macc_seq.sv
// Dot-product sequencer driving an external combinational MACC: acc = bias + sum(x*w).
// Optional macro MACC_SEQ_RELU_EN applies a ReLU to res_data (accumulator unaffected).
module macc_seq
  import neural_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic [DATA_W-1:0] cfg_bias,
  output logic              busy,
  input  logic              op_valid,
  input  logic [DATA_W-1:0] op_x,
  input  logic [DATA_W-1:0] op_w,
  output logic              op_ready,
  output logic [DATA_W-1:0] m_in0,
  output logic [DATA_W-1:0] m_in1,
  output logic [DATA_W-1:0] m_acc,
  input  logic [DATA_W-1:0] m_out,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  input  logic              res_ready
);

  state_t             state_reg, state_next;
  logic [DATA_W-1:0]  acc_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               hs;
  logic               start_ok;

  assign m_in0    = op_x;
  assign m_in1    = op_w;
  assign m_acc    = acc_reg;
  assign hs       = op_valid & op_ready;
  assign start_ok = start & (state_reg == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (cfg_len == '0) ? DONE : ACC;
        end
      end
      ACC: begin
        if (hs && (cnt_reg == CNT_W'(1))) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    op_ready  = 1'b0;
    res_valid = 1'b0;
    unique case (state_reg)
      IDLE: ;
      ACC: begin
        busy     = 1'b1;
        op_ready = 1'b1;
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // The MACC result is only captured on a handshake; stalls hold everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (start_ok) begin
      acc_reg <= cfg_bias;
      cnt_reg <= cfg_len;
    end else if (hs) begin
      acc_reg <= m_out;
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  // Result is driven to zero outside DONE so idle and reset output values agree.
  always_comb begin
    res_data = '0;
    if (res_valid) begin
`ifdef MACC_SEQ_RELU_EN
      res_data = acc_reg[DATA_W-1] ? '0 : acc_reg;
`else
      res_data = acc_reg;
`endif
    end
  end

endmodule

// File: tb/tb_macc_seq.sv
// Directed bench for macc_seq with a behavioural MACC and an expected-result scoreboard.
module tb_macc_seq;

  localparam int DW = 16;
  localparam int CW = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [CW-1:0]        cfg_len = '0;
  logic signed [DW-1:0] cfg_bias = '0;
  logic                 busy;
  logic                 op_valid = 1'b0;
  logic signed [DW-1:0] op_x = '0;
  logic signed [DW-1:0] op_w = '0;
  logic                 op_ready;
  logic signed [DW-1:0] m_in0, m_in1, m_acc, m_out;
  logic                 res_valid;
  logic signed [DW-1:0] res_data;
  logic                 res_ready = 1'b0;

  int n_total = 0;
  int n_pass  = 0;

  logic signed [DW-1:0] exp_q[$];
  int px[4];
  int pw[4];

  always #5 clk = ~clk;

  // Behavioural MACC: in0*in1+in_acc truncated to DW bits.
  assign m_out = m_in0 * m_in1 + m_acc;

  macc_seq #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .cfg_bias(cfg_bias),
    .busy(busy), .op_valid(op_valid), .op_x(op_x), .op_w(op_w), .op_ready(op_ready),
    .m_in0(m_in0), .m_in1(m_in1), .m_acc(m_acc), .m_out(m_out),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic signed [DW-1:0] model(input int bias, input int len);
    logic signed [DW-1:0] a;
    logic signed [DW-1:0] p;
    a = DW'(bias);
    for (int i = 0; i < len; i++) begin
      p = DW'(px[i] * pw[i]);
      a = a + p;
    end
`ifdef MACC_SEQ_RELU_EN
    if (a < 0) a = '0;
`endif
    return a;
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic start_job(input int bias, input int len);
    exp_q.push_back(model(bias, len));
    start    = 1'b1;
    cfg_len  = CW'(len);
    cfg_bias = DW'(bias);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed_pair(input int x, input int w, input int stall);
    op_valid = 1'b0;
    for (int s = 0; s < stall; s++) begin
      check("stall_op_ready", op_ready, 1);
      @(posedge clk); #1;
    end
    op_valid = 1'b1;
    op_x = DW'(x);
    op_w = DW'(w);
    #1;
    check("m_in0_pass", m_in0, DW'(x));
    check("m_in1_pass", m_in1, DW'(w));
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic wait_result(input int hold, input bit pulse_start, output int waited);
    logic signed [DW-1:0] exp;
    waited = 0;
    while (!res_valid && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("res_valid_seen", res_valid, 1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check("res_data", res_data, exp);
    check("done_busy", busy, 1);
    check("done_op_ready", op_ready, 0);
    for (int h = 0; h < hold; h++) begin
      if (pulse_start && h == 2) begin
        start = 1'b1; cfg_len = '0; cfg_bias = 16'sd999;
      end
      @(posedge clk); #1;
      start = 1'b0;
      check("hold_res_data", res_data, exp);
      check("hold_busy", busy, 1);
      check("hold_res_valid", res_valid, 1);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("post_res_valid", res_valid, 0);
    check("post_busy", busy, 0);
  endtask

  initial begin
    int waited;

    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_op_ready", op_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Job 1: single pair, no stall
    px[0] = 10; pw[0] = 15;
    check("j1_idle_op_ready", op_ready, 0);
    start_job(0, 1);
    feed_pair(10, 15, 0);
    wait_result(0, 1'b0, waited);
    check("j1_latency", waited, 0);

    // Job 2: stalls between pairs
    px[0] = 70; pw[0] = 8; px[1] = -7; pw[1] = 5; px[2] = 2; pw[2] = -3;
    start_job(100, 3);
    feed_pair(70, 8, 0);
    feed_pair(-7, 5, 2);
    feed_pair(2, -3, 2);
    wait_result(0, 1'b0, waited);
    check("j2_latency", waited, 0);
    check("j2_idle_op_ready", op_ready, 0);

    // Job 3: zero length
    start_job(-42, 0);
    wait_result(0, 1'b0, waited);
    check("j3_latency", waited, 0);

    // Job 4: backpressure with an ignored start
    px[0] = 3; pw[0] = 4; px[1] = -2; pw[1] = 6;
    start_job(5, 2);
    feed_pair(3, 4, 0);
    feed_pair(-2, 6, 1);
    wait_result(5, 1'b1, waited);
    @(posedge clk); #1;
    check("j4_no_extra_job", busy, 0);
    check("j4_no_extra_res", res_valid, 0);

    // Job 5: two's-complement wrap
    px[0] = 1; pw[0] = 1;
    start_job(32767, 1);
    feed_pair(1, 1, 0);
    wait_result(0, 1'b0, waited);

    // Job 6: asynchronous reset mid-job, then a clean job
    px[0] = 2; pw[0] = 2; px[1] = 2; pw[1] = 2; px[2] = 2; pw[2] = 2; px[3] = 2; pw[3] = 2;
    start_job(1, 4);
    feed_pair(2, 2, 0);
    feed_pair(2, 2, 0);
    check("j6_mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("j6_rst_busy", busy, 0);
    check("j6_rst_op_ready", op_ready, 0);
    check("j6_rst_res_valid", res_valid, 0);
    check("j6_rst_res_data", res_data, 0);
    check("j6_rst_acc", m_acc, 0);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("j6_after_rst_res_valid", res_valid, 0);
    px[0] = 3; pw[0] = 4;
    start_job(0, 1);
    feed_pair(3, 4, 0);
    wait_result(0, 1'b0, waited);
    check("j6_latency", waited, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
